// File: rtl/blocking_peer.sv
// Local valid/ready endpoint for a partner's blocking sync/notify channels.
// One FIFO per direction; every handshake output comes from registered occupancy.
module blocking_peer_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // A full FIFO refuses a push even when it pops on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end
endmodule

module blocking_peer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_sync,
    input  logic             tx_notify,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_notify,
    output logic             rx_sync,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      tx_count,
    output logic [15:0]      rx_count
);
    logic tx_empty;
    logic tx_full;
    logic rx_empty;
    logic rx_full;

    blocking_peer_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_tx (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (tx_notify),
        .head      (tx_data),
        .empty     (tx_empty),
        .full      (tx_full)
    );

    blocking_peer_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_notify),
        .push_data (rx_data),
        .pop       (out_ready),
        .head      (out_data),
        .empty     (rx_empty),
        .full      (rx_full)
    );

    assign in_ready  = !tx_full;
    assign tx_sync   = !tx_empty;
    assign rx_sync   = !rx_full;
    assign out_valid = !rx_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_count <= '0;
            rx_count <= '0;
        end else begin
            if (tx_sync && tx_notify) begin
                tx_count <= tx_count + 16'd1;
            end
            if (rx_sync && rx_notify) begin
                rx_count <= rx_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_blocking_peer.sv
// Bench for blocking_peer: vector table, hand sequences, random vs queue model.
module tb_blocking_peer;
    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] tx_data;
    logic             tx_sync;
    logic             tx_notify = 1'b0;
    logic [WIDTH-1:0] rx_data = '0;
    logic             rx_notify = 1'b0;
    logic             rx_sync;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [15:0]      tx_count;
    logic [15:0]      rx_count;

    blocking_peer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tx_data   (tx_data),
        .tx_sync   (tx_sync),
        .tx_notify (tx_notify),
        .rx_data   (rx_data),
        .rx_notify (rx_notify),
        .rx_sync   (rx_sync),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tx_count  (tx_count),
        .rx_count  (rx_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: plain queues and wrapping counters.
    logic [WIDTH-1:0] txq[$];
    logic [WIDTH-1:0] rxq[$];
    logic [15:0]      m_txc = '0;
    logic [15:0]      m_rxc = '0;

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        tn;
        logic        rn;
        logic [31:0] rd;
        logic        ordy;
        logic        e_txs;
        logic [31:0] e_txd;
        logic        e_ir;
        logic        e_rxs;
        logic        e_ov;
        logic [31:0] e_od;
        logic [15:0] e_tc;
        logic [15:0] e_rc;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(
        logic iv, logic [31:0] id, logic tn, logic rn, logic [31:0] rd,
        logic ordy, logic txs, logic [31:0] txd, logic ir, logic rxs,
        logic ov, logic [31:0] od, logic [15:0] tc, logic [15:0] rc);
        vec_t v;
        v.iv = iv; v.id = id; v.tn = tn; v.rn = rn; v.rd = rd;
        v.ordy = ordy; v.e_txs = txs; v.e_txd = txd; v.e_ir = ir;
        v.e_rxs = rxs; v.e_ov = ov; v.e_od = od; v.e_tc = tc;
        v.e_rc = rc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("tx_sync", {31'd0, tx_sync}, {31'd0, txq.size() != 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, txq.size() < DEPTH});
        if (txq.size() != 0) chk("tx_data", tx_data, txq[0]);
        chk("rx_sync", {31'd0, rx_sync}, {31'd0, rxq.size() < DEPTH});
        chk("out_valid", {31'd0, out_valid}, {31'd0, rxq.size() != 0});
        if (rxq.size() != 0) chk("out_data", out_data, rxq[0]);
        chk("tx_count", {16'd0, tx_count}, {16'd0, m_txc});
        chk("rx_count", {16'd0, rx_count}, {16'd0, m_rxc});
    endtask

    // Drive one cycle of inputs, clock it, advance the model.
    task automatic cyc(input logic iv, input logic [31:0] id,
                       input logic tn, input logic rn,
                       input logic [31:0] rd, input logic ordy,
                       input bit ck);
        bit txx;
        bit psh;
        bit rxx;
        bit pp;
        in_valid = iv; in_data = id; tx_notify = tn;
        rx_notify = rn; rx_data = rd; out_ready = ordy;
        txx = (txq.size() != 0) && tn;
        psh = iv && (txq.size() < DEPTH);
        rxx = (rxq.size() < DEPTH) && rn;
        pp  = ordy && (rxq.size() != 0);
        @(posedge clk);
        #1;
        if (txx) begin txq.delete(0); m_txc = m_txc + 16'd1; end
        if (psh) txq.push_back(id);
        if (pp) rxq.delete(0);
        if (rxx) begin rxq.push_back(rd); m_rxc = m_rxc + 16'd1; end
        if (ck) chk_model();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tx_sync"}, {31'd0, tx_sync}, 32'd0);
        chk({tag, "_rx_sync"}, {31'd0, rx_sync}, 32'd1);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_tx_data"}, tx_data, 32'd0);
        chk({tag, "_out_data"}, out_data, 32'd0);
        chk({tag, "_tx_count"}, {16'd0, tx_count}, 32'd0);
        chk({tag, "_rx_count"}, {16'd0, rx_count}, 32'd0);
    endtask

    initial begin
        tbl[0]  = mk(1, 32'h11, 1, 0, 0,   0, 1, 32'h11, 1, 1, 0, 0,   3'd0, 0);
        tbl[1]  = mk(1, 32'h22, 1, 0, 0,   0, 1, 32'h22, 1, 1, 0, 0,   1, 0);
        tbl[2]  = mk(1, 32'h33, 1, 0, 0,   0, 1, 32'h33, 1, 1, 0, 0,   2, 0);
        tbl[3]  = mk(0, 0,      1, 0, 0,   0, 0, 0,      1, 1, 0, 0,   3, 0);
        tbl[4]  = mk(0, 0,      0, 0, 0,   0, 0, 0,      1, 1, 0, 0,   3, 0);
        tbl[5]  = mk(0, 0,      0, 1, 100, 0, 0, 0,      1, 1, 1, 100, 3, 1);
        tbl[6]  = mk(0, 0,      0, 1, 101, 0, 0, 0,      1, 1, 1, 100, 3, 2);
        tbl[7]  = mk(0, 0,      0, 1, 102, 0, 0, 0,      1, 1, 1, 100, 3, 3);
        tbl[8]  = mk(0, 0,      0, 1, 103, 0, 0, 0,      1, 0, 1, 100, 3, 4);
        tbl[9]  = mk(0, 0,      0, 1, 104, 1, 0, 0,      1, 1, 1, 101, 3, 4);
        tbl[10] = mk(0, 0,      0, 1, 104, 1, 0, 0,      1, 1, 1, 102, 3, 5);
        tbl[11] = mk(0, 0,      0, 1, 105, 1, 0, 0,      1, 1, 1, 103, 3, 6);
        tbl[12] = mk(0, 0,      0, 0, 0,   1, 0, 0,      1, 1, 1, 104, 3, 6);
        tbl[13] = mk(0, 0,      0, 0, 0,   1, 0, 0,      1, 1, 1, 105, 3, 6);
        tbl[14] = mk(0, 0,      0, 0, 0,   1, 0, 0,      1, 1, 0, 0,   3, 6);

        // Reset held with a pending push request.
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 32'hAA;
        #1;
        chk_reset_vals("rst0");
        @(posedge clk); #1;
        chk_reset_vals("rst1");
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(1, 32'hAA, 0, 0, 0, 0, 1);
        chk("first_push_sync", {31'd0, tx_sync}, 32'd1);
        chk("first_push_data", tx_data, 32'hAA);

        // Table-driven vectors start from a clean reset.
        rst = 1'b1; #1;
        txq.delete(); rxq.delete(); m_txc = '0; m_rxc = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].iv, tbl[i].id, tbl[i].tn, tbl[i].rn, tbl[i].rd,
                tbl[i].ordy, 0);
            chk($sformatf("t%0d_tx_sync", i), {31'd0, tx_sync},
                {31'd0, tbl[i].e_txs});
            if (tbl[i].e_txs)
                chk($sformatf("t%0d_tx_data", i), tx_data, tbl[i].e_txd);
            chk($sformatf("t%0d_in_ready", i), {31'd0, in_ready},
                {31'd0, tbl[i].e_ir});
            chk($sformatf("t%0d_rx_sync", i), {31'd0, rx_sync},
                {31'd0, tbl[i].e_rxs});
            chk($sformatf("t%0d_out_valid", i), {31'd0, out_valid},
                {31'd0, tbl[i].e_ov});
            if (tbl[i].e_ov)
                chk($sformatf("t%0d_out_data", i), out_data, tbl[i].e_od);
            chk($sformatf("t%0d_tx_count", i), {16'd0, tx_count},
                {16'd0, tbl[i].e_tc});
            chk($sformatf("t%0d_rx_count", i), {16'd0, rx_count},
                {16'd0, tbl[i].e_rc});
        end

        // TX backpressure: fifth value waits for room.
        for (int i = 1; i <= 4; i++) cyc(1, 32'hA0 + i, 0, 0, 0, 0, 1);
        chk("bp_full", {31'd0, in_ready}, 32'd0);
        cyc(1, 32'hA5, 0, 0, 0, 0, 1);
        chk("bp_held_head", tx_data, 32'hA1);
        cyc(1, 32'hA5, 1, 0, 0, 0, 1);
        chk("bp_pop1_head", tx_data, 32'hA2);
        chk("bp_pop1_ready", {31'd0, in_ready}, 32'd1);
        cyc(1, 32'hA5, 1, 0, 0, 0, 1);
        chk("bp_pop2_head", tx_data, 32'hA3);
        cyc(0, 0, 1, 0, 0, 0, 1);
        chk("bp_head4", tx_data, 32'hA4);
        cyc(0, 0, 1, 0, 0, 0, 1);
        chk("bp_head5", tx_data, 32'hA5);
        cyc(0, 0, 1, 0, 0, 0, 1);
        chk("bp_drained", {31'd0, tx_sync}, 32'd0);
        chk("bp_count", {16'd0, tx_count}, 32'd8);

        // Randomized traffic in both directions.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 1) == 1, $urandom,
                $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                $urandom, $urandom_range(0, 1) == 1, 1);
        end

        // Counter wrap, then reset during a live transfer.
        rst = 1'b1; #1;
        txq.delete(); rxq.delete(); m_txc = '0; m_rxc = '0;
        chk_reset_vals("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 70000 && m_txc != 16'hFFFE; i++)
            cyc(1, i, 1, 0, 0, 0, 0);
        chk("wrap_pre", {16'd0, tx_count}, 32'h0000FFFE);
        for (int i = 0; i < 3; i++) cyc(1, 32'hC0 + i, 1, 0, 0, 0, 1);
        chk("wrap_post", {16'd0, tx_count}, 32'h00000001);
        chk("wrap_active", {31'd0, tx_sync}, 32'd1);
        rst = 1'b1; #1;
        chk("rst_live_count", {16'd0, tx_count}, 32'd0);
        chk("rst_live_sync", {31'd0, tx_sync}, 32'd0);
        chk("rst_live_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_live_data", tx_data, 32'd0);
        @(posedge clk); #1;
        chk("rst_live_hold", {16'd0, tx_count}, 32'd0);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/blocking_peer.md
# blocking_peer

Counterpart endpoint for modules that expose blocking sync/notify ports (an input channel with data/sync/notify, and an output channel with data/sync/notify). It drives data into a partner's blocking input and drains a partner's blocking output. Each direction is buffered by a small FIFO behind a local valid/ready interface. Testbenches and integration wrappers use it to connect local logic to the blocking-channel protocol without stalling either side.

## Interface
- DEPTH, 4: entries per FIFO, power of two, ≥2
- WIDTH, 32: data width (matches integer channel)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_data  in  WIDTH  local data to send to partner
- in_valid  in  1  local push request
- in_ready  out  1  TX FIFO not full
- tx_data  out  WIDTH  to partner's blocking input data
- tx_sync  out  1  to partner's input sync; high when TX FIFO holds data
- tx_notify  in  1  partner's input notify; partner ready to take data
- rx_data  in  WIDTH  partner's blocking output data
- rx_notify  in  1  partner's output notify; partner offers data
- rx_sync  out  1  to partner's output sync; high when RX FIFO not full
- out_data  out  WIDTH  head of RX FIFO
- out_valid  out  1  RX FIFO not empty
- out_ready  in  1  local pop request
- tx_count  out  16  completed TX transfers, wraps at 2^16
- rx_count  out  16  completed RX transfers, wraps at 2^16

## Operation
- A TX transfer occurs on a rising edge where tx_sync && tx_notify. On that edge the TX FIFO head pops and tx_count increments.
- An RX transfer occurs on a rising edge where rx_sync && rx_notify. On that edge rx_data is written to the RX FIFO and rx_count increments.
- Local push occurs on in_valid && in_ready. Local pop occurs on out_valid && out_ready.
- tx_data always equals the TX FIFO head. It holds its value while tx_sync is high and no transfer occurs.
- tx_sync = TX not empty. rx_sync = RX not full. in_ready = TX not full. out_valid = RX not empty. All are derived only from registered occupancy, with no combinational path from any input.
- When a FIFO is full, no push is accepted, even if a pop occurs in the same cycle. This costs a one-cycle bubble.
- Simultaneous push and pop on a non-full, non-empty FIFO keeps occupancy unchanged. Both pointers advance.
- Simultaneous push and pop on an empty FIFO is impossible, because the pop requires non-empty.
- Pointers are log2(DEPTH)+1 bits wide. full = MSBs differ and the remaining bits are equal.
- Counters wrap from 0xFFFF to 0x0000 without a flag.
- Data ignored by the block:
  - rx_data when rx_sync is low.
  - in_data when in_ready is low.

## Timing
- Reset values:
  - tx_sync=0, rx_sync=1, in_ready=1, out_valid=0.
  - tx_data=0, out_data=0 (storage cleared).
  - tx_count=0, rx_count=0.
  - All pointers are 0.
- Reset asserted mid-transfer discards all FIFO contents immediately. Partial handshakes are dropped, and no count is recorded.
- Latency:
  - Local push at edge N gives tx_sync=1 and tx_data valid after edge N.
  - An RX transfer at edge N gives out_valid=1 after edge N.
- Throughput: one transfer per cycle per direction, sustained while the FIFO is neither full nor empty.
- tx_sync stays asserted until the TX FIFO empties. It never drops while data is pending.

## Test plan
- Reset with in_valid=1 held → all outputs at reset values while rst=1. First push occurs on the first edge after rst falls.
- Push 0x11, 0x22, 0x33 with tx_notify=1 constantly → tx_data shows 0x11, 0x22, 0x33 on consecutive cycles. tx_count reaches 3, then tx_sync=0.
- tx_notify=0, push 5 values with DEPTH=4 → in_ready drops after the 4th push and the 5th is held. Raise tx_notify → the 5th is accepted one cycle after the first pop. Order is preserved.
- rx_notify=1 with rx_data counting 100..105, out_ready=0 → rx_sync falls after 4 transfers (100..103) and rx_count=4. Set out_ready=1 → values 100..105 appear in order. rx_count ends at 6.
- Preload tx_count to 0xFFFE via 2^16-2 transfers, then do 3 more → count reads 0x0001. Assert rst during an active TX transfer → count is 0, FIFO is empty, and tx_sync=0 the same cycle.
